// File: rtl/seq_shl_pkg.sv
// Shared types for the sequential left shifter.
// State encoding and counter-width helper.
package seq_shl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/shl_cnt.sv
// Loadable down-counter tracking the remaining shift steps.
module shl_cnt #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_shl.sv
// Multi-cycle left shifter, one bit position per clock.
// SEQ_SHL_ROTATE_EN selects rotate-left instead of logical shift.
module seq_shl
    import seq_shl_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] d
);

    localparam int CNTW = cnt_w(DATAWIDTH);

    state_t               state, state_nx;
    logic [DATAWIDTH-1:0] work, step;
    logic [CNTW-1:0]      cnt, cnt_ld;
    logic                 load, dec, cap, zero;

`ifdef SEQ_SHL_ROTATE_EN
    // Power-of-two width makes the modulo a simple mask.
    localparam logic [DATAWIDTH-1:0] ROT_MASK = DATAWIDTH'(DATAWIDTH - 1);

    assign cnt_ld = CNTW'(sh_amt & ROT_MASK);
    assign step   = {work[DATAWIDTH-2:0], work[DATAWIDTH-1]};
`else
    localparam logic [DATAWIDTH:0] DW_V = (DATAWIDTH + 1)'(DATAWIDTH);

    assign cnt_ld = ({1'b0, sh_amt} >= DW_V) ? CNTW'(DATAWIDTH)
                                             : CNTW'(sh_amt);
    assign step   = {work[DATAWIDTH-2:0], 1'b0};
`endif

    shl_cnt #(
        .W(CNTW)
    ) u_cnt (
        .Clk     (Clk),
        .Rst     (Rst),
        .load    (load),
        .dec     (dec),
        .load_val(cnt_ld),
        .cnt     (cnt),
        .zero    (zero)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        dec      = 1'b0;
        cap      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (zero) begin
                    cap      = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            work <= '0;
            d    <= '0;
        end else begin
            if (load) begin
                work <= a;
            end else if (dec) begin
                work <= step;
            end
            if (cap) begin
                d <= work;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shl.sv
// Self-checking bench for seq_shl: timeline model plus directed vectors.
module tb_seq_shl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] sh_amt = '0;
    logic       busy, done;
    logic [7:0] d;

    int errors = 0;
    int checks = 0;

    seq_shl #(.DATAWIDTH(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .sh_amt(sh_amt),
        .busy  (busy),
        .done  (done),
        .d     (d)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Operation-level model: steps and result from plain arithmetic.
    function automatic int model_n(input int sh);
`ifdef SEQ_SHL_ROTATE_EN
        return sh % 8;
`else
        return (sh > 8) ? 8 : sh;
`endif
    endfunction

    function automatic int model_res(input int av, input int sh);
        int n;
        n = model_n(sh);
`ifdef SEQ_SHL_ROTATE_EN
        return ((av << n) | (av >> (8 - n))) & 255;
`else
        return (av << n) & 255;
`endif
    endfunction

    int   cyc = 0;
    int   done_edge = 0;
    bit   m_active = 1'b0;
    bit   m_done = 1'b0;
    int   m_res = 0;
    int   m_d = 0;
    bit   chk_en = 1'b0;

    always @(posedge Clk) begin
        cyc    <= cyc + 1;
        m_done <= 1'b0;
        if (Rst) begin
            m_active <= 1'b0;
            m_d      <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active  <= 1'b1;
                done_edge <= cyc + model_n(int'(sh_amt)) + 1;
                m_res     <= model_res(int'(a), int'(sh_amt));
            end
        end else if (cyc == done_edge) begin
            m_d    <= m_res;
            m_done <= 1'b1;
        end else if (cyc == done_edge + 1) begin
            m_active <= 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("model_busy", int'(busy), int'(m_active));
            check("model_done", int'(done), int'(m_done));
            check("model_d", int'(d), m_d);
        end
    end

    // One op: start for one cycle, wait for done, check result and latency.
    task automatic run_op(input logic [7:0] av, input logic [7:0] sv,
                          input int exp_d, input int exp_lat);
        int lat;
        lat = 0;
        @(posedge Clk);
        #2;
        a      = av;
        sh_amt = sv;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            check("op_timeout", 0, 1);
        end else begin
            check("op_d", int'(d), exp_d);
            check("op_latency", lat, exp_lat);
            check("op_busy_in_done", int'(busy), 1);
            @(posedge Clk);
            #1;
            check("op_idle_after", int'(busy), 0);
            check("op_d_held", int'(d), exp_d);
        end
    endtask

    initial begin
        int prev;
        int ndone;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_d", int'(d), 0);
        #1;
        Rst    = 1'b0;
        chk_en = 1'b1;

`ifdef SEQ_SHL_ROTATE_EN
        run_op(8'h81, 8'd1, 8'h03, 2);
        run_op(8'h81, 8'd9, 8'h03, 2);
        run_op(8'd20, 8'd3, 160, 4);
        run_op(8'hA5, 8'd8, 8'hA5, 1);
`else
        run_op(8'd20, 8'd1, 40, 2);
        run_op(8'd20, 8'd3, 160, 4);
        run_op(8'd40, 8'd4, 128, 5);
        run_op(8'hA5, 8'd0, 8'hA5, 1);
        run_op(8'hA5, 8'd9, 0, 9);
        run_op(8'hFF, 8'd7, 8'h80, 8);
        run_op(8'd3, 8'd200, 0, 9);

        // Reset two cycles into a 5-step op; leave a nonzero d first.
        run_op(8'd7, 8'd1, 14, 2);
        @(posedge Clk);
        #2;
        a      = 8'd3;
        sh_amt = 8'd5;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_d", int'(d), 0);
        ndone = 0;
        repeat (10) begin
            @(posedge Clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_op(8'd3, 8'd2, 12, 3);

        // start held high: one result every n+3 = 5 cycles.
        @(posedge Clk);
        #2;
        a      = 8'd1;
        sh_amt = 8'd2;
        start  = 1'b1;
        prev   = -1;
        ndone  = 0;
        for (int i = 0; i < 26; i++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                ndone++;
                check("hold_d", int'(d), 4);
                if (prev >= 0) check("hold_period", i - prev, 5);
                prev = i;
            end
        end
        check("hold_count", ndone, 5);
        start = 1'b0;
        repeat (6) @(posedge Clk);
`endif

        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
